wp_encode: RTL and testbench

WP_ENCODE -- requirements
Module: wp_encode

---
 rtl/wp_encode.sv | 70 +++++++
 tb/tb_wp_encode.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/wp_encode.sv
// ---------------------------------------------------------------------------
// wp_encode: registered 8-to-3 priority encoder.
//
// Parameters
//   MSB_PRIORITY  1 = highest set Din index wins, 0 = lowest set index wins
//
// Ports
//   clk    in   1  sole clock, all state updates on rising edge
//   rst    in   1  synchronous active-high reset, overrides en/Din
//   en     in   1  encode enable; when low the outputs go idle next edge
//   Din    in   8  request vector, bit i = request for code i
//   Dout   out  3  registered index of the winning request (0 when idle)
//   valid  out  1  registered, high when Dout holds a real code
//   multi  out  1  registered, high when more than one request was set
// ---------------------------------------------------------------------------
module wp_encode #(
    parameter int MSB_PRIORITY = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] Din,
    output logic [2:0] Dout,
    output logic       valid,
    output logic       multi
);

    logic [2:0] dout_d,  dout_q;
    logic       valid_d, valid_q;
    logic       multi_d, multi_q;

    always_comb begin
        dout_d  = '0;
        valid_d = 1'b0;
        multi_d = 1'b0;
        if (en && (Din != '0)) begin
            valid_d = 1'b1;
            // Clearing the lowest set bit leaves something only if >1 bit set.
            multi_d = ((Din & (Din - 8'd1)) != '0);
            if (MSB_PRIORITY != 0) begin
                // Ascending scan: the last hit, i.e. the highest index, sticks.
                for (int unsigned i = 0; i < 8; i++) begin
                    if (Din[i]) dout_d = i[2:0];
                end
            end else begin
                // Descending scan: the last hit, i.e. the lowest index, sticks.
                for (int unsigned i = 0; i < 8; i++) begin
                    if (Din[7-i]) dout_d = 3'(7 - i);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            dout_q  <= dout_d;
            valid_q <= valid_d;
            multi_q <= multi_d;
        end
    end

    assign Dout  = dout_q;
    assign valid = valid_q;
    assign multi = multi_q;

endmodule

// File: tb/tb_wp_encode.sv
// ---------------------------------------------------------------------------
// tb_wp_encode: directed-vector bench for wp_encode. Two instances share the
// same stimulus, one per priority direction, so each vector checks both.
// ---------------------------------------------------------------------------
module tb_wp_encode;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] Din;

    logic [2:0] dout_hi, dout_lo;
    logic       valid_hi, valid_lo;
    logic       multi_hi, multi_lo;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    wp_encode #(.MSB_PRIORITY(1)) dut_hi (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .Din   (Din),
        .Dout  (dout_hi),
        .valid (valid_hi),
        .multi (multi_hi)
    );

    wp_encode #(.MSB_PRIORITY(0)) dut_lo (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .Din   (Din),
        .Dout  (dout_lo),
        .valid (valid_lo),
        .multi (multi_lo)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Check both instances: expected (code, valid, multi) for MSB- and LSB-priority.
    task automatic check_both(input string tag,
                              input logic [2:0] d_hi, input logic [2:0] d_lo,
                              input logic v, input logic m);
        check({tag, " hi.Dout"},  {5'b0, dout_hi}, {5'b0, d_hi});
        check({tag, " hi.valid"}, {7'b0, valid_hi}, {7'b0, v});
        check({tag, " hi.multi"}, {7'b0, multi_hi}, {7'b0, m});
        check({tag, " lo.Dout"},  {5'b0, dout_lo}, {5'b0, d_lo});
        check({tag, " lo.valid"}, {7'b0, valid_lo}, {7'b0, v});
        check({tag, " lo.multi"}, {7'b0, multi_lo}, {7'b0, m});
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset wins over en=1 with all requests set.
        rst = 1'b1; en = 1'b1; Din = 8'hFF;
        tick();
        check_both("reset", 3'd0, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // One-hot sweep with en alternating.
        for (int i = 0; i < 8; i++) begin
            Din = 8'(1 << i);
            en  = 1'b0;
            tick();
            check_both($sformatf("onehot%0d en0", i), 3'd0, 3'd0, 1'b0, 1'b0);
            en = 1'b1;
            tick();
            check_both($sformatf("onehot%0d en1", i), 3'(i), 3'(i), 1'b1, 1'b0);
        end

        // Multi-hot: 0010_0101 -> hi wins 5, lo wins 0.
        en = 1'b1; Din = 8'b0010_0101;
        tick();
        check_both("multi 25", 3'd5, 3'd0, 1'b1, 1'b1);

        // Extremes both set: 1000_0001 -> 7 / 0.
        Din = 8'h81;
        tick();
        check_both("multi 81", 3'd7, 3'd0, 1'b1, 1'b1);

        // Two adjacent middle bits: 0001_1000 -> 4 / 3.
        Din = 8'h18;
        tick();
        check_both("multi 18", 3'd4, 3'd3, 1'b1, 1'b1);

        // All set: 7 / 0.
        Din = 8'hFF;
        tick();
        check_both("multi FF", 3'd7, 3'd0, 1'b1, 1'b1);

        // Zero input with en=1.
        Din = 8'h00;
        tick();
        check_both("zero", 3'd0, 3'd0, 1'b0, 1'b0);

        // en=0 with all requests set.
        en = 1'b0; Din = 8'hFF;
        tick();
        check_both("en0 FF", 3'd0, 3'd0, 1'b0, 1'b0);

        // Latency: mid-cycle Din change has no effect until the next edge.
        en = 1'b1; Din = 8'h02;
        tick();
        check_both("lat pre", 3'd1, 3'd1, 1'b1, 1'b0);
        #3 Din = 8'h40;
        #1;
        check_both("lat mid", 3'd1, 3'd1, 1'b1, 1'b0);
        tick();
        check_both("lat post", 3'd6, 3'd6, 1'b1, 1'b0);

        // Mid-operation reset, then resume.
        Din = 8'h80;
        tick();
        check_both("mid run", 3'd7, 3'd7, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        check_both("mid rst", 3'd0, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        check_both("mid resume", 3'd7, 3'd7, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
